// File: rtl/instr_fetch_pkg.sv
`default_nettype none
// ============================================================================
// Package  : instr_fetch_pkg
// Brief    : Shared state encoding and constants for the instruction-fetch stage.
// Revision : 1.0
// ============================================================================
package instr_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    WAIT  = 3'd2,
    VALID = 3'd3,
    ERR   = 3'd4
  } fetch_state_t;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;
  localparam logic [1:0]  WORD_ALIGN_MASK = 2'b11;

  function automatic logic is_word_aligned(input logic [1:0] addr_lsbs);
    return (addr_lsbs & WORD_ALIGN_MASK) == 2'b00;
  endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_timer.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_timer
// Brief    : Saturating bus-wait counter; expires on the last allowed wait cycle.
// Revision : 1.0
// ============================================================================
module instr_fetch_timer #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic clr,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int TW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TW-1:0] c_MAX = '1;

  logic [TW-1:0] r_count;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != c_MAX)) begin
      r_count <= r_count + TW'(1);
    end
  end

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_disabled
      assign o_expired = 1'b0;
    end else begin : g_enabled
      localparam logic [TW-1:0] c_LAST = TW'(TIMEOUT_CYCLES - 1);
      assign o_expired = (r_count == c_LAST);
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Brief    : PC-driven instruction fetch with req/ack memory bus and valid/ready
//            hand-off to decode; advances the PC only on consumed instructions.
// Revision : 1.0
// ============================================================================
module instr_fetch #(
  parameter int          TIMEOUT_CYCLES = 16,
  parameter logic [31:0] NOP_INSTR      = instr_fetch_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        clr,
  input  logic        fetch_en,
  input  logic [31:0] pc_val,
  input  logic        flush,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic        pc_inc,
  output logic        pc_hold,
  output logic        misalign_err,
  output logic        bus_err
);

  import instr_fetch_pkg::*;

  fetch_state_t r_state;
  logic [31:0]  r_addr;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         r_flush_pending;
  logic         r_misalign_err;
  logic         r_bus_err;

  logic w_timer_clear;
  logic w_timer_en;
  logic w_timeout;
  logic w_drop;
  logic w_accept;

  assign w_timer_clear = (r_state == REQ);
  assign w_timer_en    = (r_state == WAIT) && !mem_ack;
  // A redirect seen anywhere in the bus cycle, including the ack cycle, voids its data.
  assign w_drop        = flush || r_flush_pending;
  assign w_accept      = (r_state == VALID) && instr_ready && !flush;

  instr_fetch_timer #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_timer (
    .clk       (clk),
    .clr       (clr),
    .i_clear   (w_timer_clear),
    .i_enable  (w_timer_en),
    .o_expired (w_timeout)
  );

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_state         <= IDLE;
      r_addr          <= '0;
      r_instr         <= NOP_INSTR;
      r_instr_pc      <= '0;
      r_flush_pending <= 1'b0;
      r_misalign_err  <= 1'b0;
      r_bus_err       <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (fetch_en) begin
            r_state <= REQ;
          end
        end
        REQ: begin
          if (!is_word_aligned(pc_val[1:0])) begin
            r_misalign_err <= 1'b1;
            r_state        <= ERR;
          end else begin
            r_addr          <= pc_val;
            r_flush_pending <= 1'b0;
            r_state         <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack) begin
            r_flush_pending <= 1'b0;
            if (w_drop) begin
              r_state <= REQ;
            end else begin
              r_instr    <= mem_rdata;
              r_instr_pc <= r_addr;
              r_state    <= VALID;
            end
          end else if (w_timeout) begin
            r_bus_err <= 1'b1;
            r_state   <= ERR;
          end else if (flush) begin
            r_flush_pending <= 1'b1;
          end
        end
        VALID: begin
          if (flush) begin
            r_state <= REQ;
          end else if (instr_ready) begin
            r_state <= fetch_en ? REQ : IDLE;
          end
        end
        ERR: begin
          r_state <= ERR;
        end
        default: begin
          r_state <= ERR;
        end
      endcase
    end
  end

  assign mem_req      = (r_state == WAIT);
  assign mem_addr     = r_addr;
  assign instr        = r_instr;
  assign instr_pc     = r_instr_pc;
  assign instr_valid  = (r_state == VALID);
  assign pc_inc       = w_accept;
  assign pc_hold      = ~w_accept;
  assign misalign_err = r_misalign_err;
  assign bus_err      = r_bus_err;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Brief    : Directed scoreboard bench for instr_fetch (TIMEOUT_CYCLES = 4).
// Revision : 1.0
// ============================================================================
module tb_instr_fetch;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        clr;
  logic        fetch_en;
  logic [31:0] pc_val;
  logic        flush;
  logic [31:0] mem_rdata;
  logic        mem_ack;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;
  logic        pc_inc;
  logic        pc_hold;
  logic        misalign_err;
  logic        bus_err;

  int   vectors     = 0;
  int   miscompares = 0;
  int   req_cnt     = 0;
  exp_t sb[$];

  always #5 clk = ~clk;

  instr_fetch #(
    .TIMEOUT_CYCLES (4),
    .NOP_INSTR      (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .clr          (clr),
    .fetch_en     (fetch_en),
    .pc_val       (pc_val),
    .flush        (flush),
    .mem_rdata    (mem_rdata),
    .mem_ack      (mem_ack),
    .mem_req      (mem_req),
    .mem_addr     (mem_addr),
    .instr        (instr),
    .instr_pc     (instr_pc),
    .instr_valid  (instr_valid),
    .instr_ready  (instr_ready),
    .pc_inc       (pc_inc),
    .pc_hold      (pc_hold),
    .misalign_err (misalign_err),
    .bus_err      (bus_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic wait_req(input logic [31:0] exp_addr);
    int n = 0;
    while (mem_req !== 1'b1 && n < 20) begin
      cyc();
      settle();
      n++;
    end
    chk("mem_req_rise", {31'd0, mem_req}, 32'd1);
    chk("mem_addr", mem_addr, exp_addr);
  endtask

  task automatic serve(input int delay, input logic [31:0] data,
                       input logic [31:0] addr, input bit keep);
    wait_req(addr);
    repeat (delay) cyc();
    mem_ack   = 1'b1;
    mem_rdata = data;
    if (keep) sb.push_back('{instr: data, pc: addr});
    cyc();
    mem_ack   = 1'b0;
    mem_rdata = '0;
    settle();
  endtask

  task automatic accept();
    exp_t e;
    chk("acc_valid", {31'd0, instr_valid}, 32'd1);
    chk("acc_pc_inc", {31'd0, pc_inc}, 32'd1);
    chk("acc_pc_hold", {31'd0, pc_hold}, 32'd0);
    vectors++;
    assert (sb.size() > 0) else begin
      miscompares++;
      $error("FAIL sb_empty: observed %0d entries expected at least 1", sb.size());
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("acc_instr", instr, e.instr);
      chk("acc_instr_pc", instr_pc, e.pc);
    end
  endtask

  initial begin
    clr = 1'b1; fetch_en = 1'b0; flush = 1'b0; mem_ack = 1'b0;
    instr_ready = 1'b0; pc_val = '0; mem_rdata = '0;
    #1 clr = 1'b0;
    #2;
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_instr", instr, 32'h0000_0013);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_pc_inc", {31'd0, pc_inc}, 32'd0);
    chk("rst_pc_hold", {31'd0, pc_hold}, 32'd1);
    chk("rst_errs", {30'd0, misalign_err, bus_err}, 32'd0);
    repeat (2) cyc();
    clr = 1'b1;
    settle();

    // Basic fetch with one wait cycle, accepted immediately.
    fetch_en = 1'b1; pc_val = 32'h100; instr_ready = 1'b1;
    serve(1, 32'h00A0_0093, 32'h100, 1'b1);
    fetch_en = 1'b0;
    accept();
    cyc(); pc_val = 32'h104; settle();
    chk("t1_single_pulse", {31'd0, pc_inc}, 32'd0);
    chk("t1_idle_valid", {31'd0, instr_valid}, 32'd0);
    chk("t1_instr_hold", instr, 32'h00A0_0093);

    // Decode stalls for five cycles.
    fetch_en = 1'b1; instr_ready = 1'b0;
    serve(0, 32'h00B0_0113, 32'h104, 1'b1);
    for (int i = 0; i < 5; i++) begin
      chk("t2_stall_valid", {31'd0, instr_valid}, 32'd1);
      chk("t2_stall_pc_inc", {31'd0, pc_inc}, 32'd0);
      chk("t2_stall_pc_hold", {31'd0, pc_hold}, 32'd1);
      chk("t2_stall_instr", instr, 32'h00B0_0113);
      cyc(); settle();
    end
    fetch_en = 1'b0; instr_ready = 1'b1;
    settle();
    accept();
    cyc(); pc_val = 32'h108; settle();
    chk("t2_no_double_pulse", {31'd0, pc_inc}, 32'd0);

    // Flush in WAIT, ack three cycles later on the last allowed wait cycle.
    fetch_en = 1'b1; instr_ready = 1'b1;
    wait_req(32'h108);
    flush = 1'b1;
    cyc(); flush = 1'b0; pc_val = 32'h200;
    cyc();
    cyc(); mem_ack = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    settle();
    chk("t3_still_waiting", {31'd0, mem_req}, 32'd1);
    cyc(); mem_ack = 1'b0; mem_rdata = '0; settle();
    chk("t3_dropped_valid", {31'd0, instr_valid}, 32'd0);
    chk("t3_req_state", {31'd0, mem_req}, 32'd0);
    chk("t3_instr_kept", instr, 32'h00B0_0113);
    chk("t3_no_bus_err", {31'd0, bus_err}, 32'd0);
    serve(0, 32'h0020_0093, 32'h200, 1'b1);
    pc_val = 32'h204;
    accept();

    // Flush and ready together in VALID.
    serve(0, 32'h0040_0093, 32'h204, 1'b0);
    flush = 1'b1; pc_val = 32'h300;
    settle();
    chk("t4_valid", {31'd0, instr_valid}, 32'd1);
    chk("t4_pc_inc", {31'd0, pc_inc}, 32'd0);
    chk("t4_pc_hold", {31'd0, pc_hold}, 32'd1);
    cyc(); flush = 1'b0; settle();
    chk("t4_req_valid", {31'd0, instr_valid}, 32'd0);
    chk("t4_req_mem_req", {31'd0, mem_req}, 32'd0);
    cyc(); settle();
    chk("t4_refetch_req", {31'd0, mem_req}, 32'd1);
    chk("t4_refetch_addr", mem_addr, 32'h300);
    fetch_en = 1'b0; mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    sb.push_back('{instr: 32'h0050_0093, pc: 32'h300});
    cyc(); mem_ack = 1'b0; mem_rdata = '0; settle();
    accept();
    cyc(); settle();
    chk("t4_idle", {31'd0, instr_valid}, 32'd0);

    // Bus timeout after four WAIT cycles.
    fetch_en = 1'b1; pc_val = 32'h400;
    wait_req(32'h400);
    for (int i = 0; i < 3; i++) begin
      cyc(); settle();
      chk("t6_wait_req", {31'd0, mem_req}, 32'd1);
      chk("t6_no_err_yet", {31'd0, bus_err}, 32'd0);
    end
    cyc(); settle();
    chk("t6_bus_err", {31'd0, bus_err}, 32'd1);
    chk("t6_err_mem_req", {31'd0, mem_req}, 32'd0);
    chk("t6_err_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_err_hold", {31'd0, pc_hold}, 32'd1);
    chk("t6_no_misalign", {31'd0, misalign_err}, 32'd0);
    repeat (3) cyc();
    settle();
    chk("t6_sticky", {31'd0, bus_err}, 32'd1);
    chk("t6_sticky_req", {31'd0, mem_req}, 32'd0);
    clr = 1'b0; #1;
    chk("t6_clr_err", {31'd0, bus_err}, 32'd0);
    cyc(); clr = 1'b1; settle();

    // Asynchronous clear in the middle of a WAIT cycle.
    pc_val = 32'h500;
    wait_req(32'h500);
    cyc(); #3;
    clr = 1'b0; #1;
    chk("t6_async_req", {31'd0, mem_req}, 32'd0);
    chk("t6_async_addr", mem_addr, 32'd0);
    cyc(); clr = 1'b1; settle();

    // Misaligned PC.
    pc_val = 32'h102; fetch_en = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(); settle();
      if (mem_req === 1'b1) req_cnt++;
    end
    chk("t5_no_req", req_cnt, 32'd0);
    chk("t5_misalign", {31'd0, misalign_err}, 32'd1);
    chk("t5_no_bus_err", {31'd0, bus_err}, 32'd0);
    chk("t5_valid", {31'd0, instr_valid}, 32'd0);
    chk("t5_hold", {31'd0, pc_hold}, 32'd1);
    clr = 1'b0; #1;
    chk("t5_clr", {31'd0, misalign_err}, 32'd0);
    cyc(); clr = 1'b1; settle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
